// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the memory port arbiter and its
// address/write-data mux.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_A = 2'b01,
        BUSY_B = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF   = 4;

    // Mux select polarity: 1 passes requester A, 0 passes requester B.
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory handshake bundle of the shared memory port.
interface mem_port_arbiter_if;

    logic        reqA;
    logic        reqB;
    logic        memReady;
    logic [31:0] memRdata;
    logic        sel;
    logic        gntA;
    logic        gntB;
    logic        memReq;
    logic        doneA;
    logic        doneB;
    logic        err;
    logic [31:0] rdata;
    logic        busy;

    modport master (
        input  reqA, reqB, memReady, memRdata,
        output sel, gntA, gntB, memReq, doneA, doneB, err, rdata, busy
    );

    modport slave (
        output reqA, reqB, memReady, memRdata,
        input  sel, gntA, gntB, memReq, doneA, doneB, err, rdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Counts BUSY cycles without memReady; tc flags the last allowed cycle.
module timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared memory port,
// with read-data capture and timeout abort.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic Clk,
    input logic Rst,
    mem_port_arbiter_if.master bus
);

    state_t      state_q, state_d;
    logic        last_a_q, last_a_d;
    logic        sel_q, sel_d;
    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;
    logic        mem_req_q, mem_req_d;
    logic        done_a_q, done_a_d;
    logic        done_b_q, done_b_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [31:0] rdata_q, rdata_d;

    logic in_busy, grant_a, cnt_en, tc;

    assign in_busy = (state_q == BUSY_A) || (state_q == BUSY_B);

    timeout_counter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo (
        .Clk    (Clk),
        .Rst    (Rst),
        .clear  (!in_busy),
        .enable (cnt_en),
        .tc     (tc)
    );

    always_comb begin
        state_d  = state_q;
        last_a_d = last_a_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        cnt_en   = 1'b0;
        // On a tie, whoever was served last yields.
        grant_a  = (bus.reqA && bus.reqB) ? !last_a_q : bus.reqA;

        case (state_q)
            IDLE: begin
                if (bus.reqA || bus.reqB)
                    state_d = grant_a ? BUSY_A : BUSY_B;
            end
            BUSY_A, BUSY_B: begin
                if (bus.memReady) begin
                    state_d  = DONE;
                    rdata_d  = bus.memRdata;
                    last_a_d = (state_q == BUSY_A);
                end else if (tc) begin
                    state_d  = DONE;
                    err_d    = 1'b1;
                    last_a_d = (state_q == BUSY_A);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs decoded from the next state so they come straight off flops.
        gnt_a_d   = (state_d == BUSY_A);
        gnt_b_d   = (state_d == BUSY_B);
        mem_req_d = gnt_a_d || gnt_b_d;
        busy_d    = (state_d != IDLE);
        done_a_d  = (state_d == DONE) && last_a_d;
        done_b_d  = (state_d == DONE) && !last_a_d;
        sel_d     = gnt_a_d ? SEL_A : (gnt_b_d ? SEL_B : sel_q);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            last_a_q  <= 1'b0;
            sel_q     <= SEL_A;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            mem_req_q <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_a_q  <= last_a_d;
            sel_q     <= sel_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            mem_req_q <= mem_req_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.sel    = sel_q;
    assign bus.gntA   = gnt_a_q;
    assign bus.gntB   = gnt_b_q;
    assign bus.memReq = mem_req_q;
    assign bus.doneA  = done_a_q;
    assign bus.doneB  = done_b_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4); inputs change and outputs
// are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic Clk = 1'b0;
    logic Rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(4), .CNT_W(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // Observed vector: {gntA, gntB, memReq, sel, busy, doneA, doneB, err}
    localparam logic [7:0] V_IDLE_SA  = 8'b0001_0000;
    localparam logic [7:0] V_IDLE_SB  = 8'b0000_0000;
    localparam logic [7:0] V_BUSY_A   = 8'b1011_1000;
    localparam logic [7:0] V_BUSY_B   = 8'b0110_1000;
    localparam logic [7:0] V_DONE_A   = 8'b0001_1100;
    localparam logic [7:0] V_DONE_B   = 8'b0000_1010;
    localparam logic [7:0] V_DONE_BE  = 8'b0000_1011;

    function automatic logic [7:0] obs();
        return {bus.gntA, bus.gntB, bus.memReq, bus.sel, bus.busy,
                bus.doneA, bus.doneB, bus.err};
    endfunction

    task automatic test_reset();
        Rst = 1'b1;
        bus.reqA = 1'b0; bus.reqB = 1'b0; bus.memReady = 1'b0; bus.memRdata = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (obs() !== V_IDLE_SA || bus.rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %b/%h want %b/%h", i, obs(), bus.rdata, V_IDLE_SA, 32'h0);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_single_a();
        bus.reqA = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clk);
            n_tests++;
            if (obs() !== V_BUSY_A) begin
                n_fail++;
                $display("FAIL single_a_busy%0d: got %b want %b", i, obs(), V_BUSY_A);
            end
            if (i == 3) begin
                bus.memReady = 1'b1; bus.memRdata = 32'hDEADBEEF;
            end
        end
        @(negedge Clk);
        n_tests++;
        if (obs() !== V_DONE_A || bus.rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_a_done: got %b/%h want %b/%h", obs(), bus.rdata, V_DONE_A, 32'hDEADBEEF);
        end
        bus.reqA = 1'b0; bus.memReady = 1'b0; bus.memRdata = '0;
        @(negedge Clk);
        n_tests++;
        if (obs() !== V_IDLE_SA || bus.rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_a_idle: got %b/%h want %b/%h", obs(), bus.rdata, V_IDLE_SA, 32'hDEADBEEF);
        end
    endtask

    task automatic test_contention();
        logic own_a;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        bus.reqA = 1'b1; bus.reqB = 1'b1; bus.memReady = 1'b1;
        for (int g = 0; g < 4; g++) begin
            own_a = (g % 2 == 0);
            bus.memRdata = 32'h1000_0000 + 32'(g);
            @(negedge Clk);
            n_tests++;
            if (obs() !== (own_a ? V_BUSY_A : V_BUSY_B)) begin
                n_fail++;
                $display("FAIL contention_busy g%0d: got %b want %b", g, obs(), own_a ? V_BUSY_A : V_BUSY_B);
            end
            @(negedge Clk);
            n_tests++;
            if (obs() !== (own_a ? V_DONE_A : V_DONE_B) || bus.rdata !== 32'h1000_0000 + 32'(g)) begin
                n_fail++;
                $display("FAIL contention_done g%0d: got %b/%h want %b/%h", g, obs(), bus.rdata,
                         own_a ? V_DONE_A : V_DONE_B, 32'h1000_0000 + 32'(g));
            end
            if (g == 3) begin
                bus.reqA = 1'b0; bus.reqB = 1'b0; bus.memReady = 1'b0;
            end
            @(negedge Clk);
            n_tests++;
            if (obs() !== (own_a ? V_IDLE_SA : V_IDLE_SB)) begin
                n_fail++;
                $display("FAIL contention_idle g%0d: got %b want %b", g, obs(), own_a ? V_IDLE_SA : V_IDLE_SB);
            end
        end
    endtask

    task automatic test_timeout();
        bus.reqB = 1'b1; bus.memReady = 1'b0; bus.memRdata = 32'hBAD0_BAD0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clk);
            n_tests++;
            if (obs() !== V_BUSY_B) begin
                n_fail++;
                $display("FAIL timeout_busy%0d: got %b want %b", i, obs(), V_BUSY_B);
            end
        end
        @(negedge Clk);
        n_tests++;
        if (obs() !== V_DONE_BE || bus.rdata !== 32'h1000_0003) begin
            n_fail++;
            $display("FAIL timeout_done: got %b/%h want %b/%h", obs(), bus.rdata, V_DONE_BE, 32'h1000_0003);
        end
        bus.reqB = 1'b0;
        @(negedge Clk);
        n_tests++;
        if (obs() !== V_IDLE_SB) begin
            n_fail++;
            $display("FAIL timeout_idle: got %b want %b", obs(), V_IDLE_SB);
        end
        // B was served last, so a tie now goes to A
        bus.reqA = 1'b1; bus.reqB = 1'b1;
        @(negedge Clk);
        n_tests++;
        if (obs() !== V_BUSY_A) begin
            n_fail++;
            $display("FAIL timeout_tie: got %b want %b", obs(), V_BUSY_A);
        end
        bus.memReady = 1'b1;
        @(negedge Clk);
        n_tests++;
        if (obs() !== V_DONE_A || bus.rdata !== 32'hBAD0_BAD0) begin
            n_fail++;
            $display("FAIL timeout_tie_done: got %b/%h want %b/%h", obs(), bus.rdata, V_DONE_A, 32'hBAD0_BAD0);
        end
        bus.reqA = 1'b0; bus.reqB = 1'b0; bus.memReady = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_collision();
        bus.reqA = 1'b1; bus.memRdata = '0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clk);
            n_tests++;
            if (obs() !== V_BUSY_A) begin
                n_fail++;
                $display("FAIL collision_busy%0d: got %b want %b", i, obs(), V_BUSY_A);
            end
            if (i == 4) begin
                bus.memReady = 1'b1; bus.memRdata = 32'h1234_5678;
            end
        end
        @(negedge Clk);
        n_tests++;
        if (obs() !== V_DONE_A || bus.rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL collision_done: got %b/%h want %b/%h", obs(), bus.rdata, V_DONE_A, 32'h1234_5678);
        end
        bus.reqA = 1'b0; bus.memReady = 1'b0;
        @(negedge Clk);
        n_tests++;
        if (obs() !== V_IDLE_SA) begin
            n_fail++;
            $display("FAIL collision_idle: got %b want %b", obs(), V_IDLE_SA);
        end
    endtask

    task automatic test_reset_mid();
        bus.reqB = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge Clk);
            n_tests++;
            if (obs() !== V_BUSY_B) begin
                n_fail++;
                $display("FAIL rstmid_busy%0d: got %b want %b", i, obs(), V_BUSY_B);
            end
        end
        Rst = 1'b1;
        @(negedge Clk);
        n_tests++;
        if (obs() !== V_IDLE_SA || bus.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_reset: got %b/%h want %b/%h", obs(), bus.rdata, V_IDLE_SA, 32'h0);
        end
        Rst = 1'b0; bus.reqB = 1'b0;
        bus.memReady = 1'b1; bus.memRdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            n_tests++;
            if (obs() !== V_IDLE_SA || bus.rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL rstmid_after%0d: got %b/%h want %b/%h", i, obs(), bus.rdata, V_IDLE_SA, 32'h0);
            end
        end
        bus.memReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_contention();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter and sequencer for the processor's shared 32-bit memory port. Instruction fetch (A) and load/store unit (B) request the port. The arbiter grants one at a time and drives `sel` of the 32-bit 2:1 address/write-data mux ahead of memory (sel=1 passes A, sel=0 passes B). It handshakes with a variable-latency memory, captures read data, and aborts stalled accesses with a timeout.

## Interface
- `TIMEOUT`, 15: maximum BUSY cycles without `memReady` before abort; legal range 2..2^CNT_W-1.
- `CNT_W`, 4: width of the timeout counter.

- `Clk` in 1: sole clock, rising edge.
- `Rst` in 1: reset, synchronous, active-high.
- `reqA` in 1: requester A wants the port; held until `doneA`.
- `reqB` in 1: requester B wants the port; held until `doneB`.
- `memReady` in 1: memory completes the current access this cycle.
- `memRdata` in 32: memory read data, valid with `memReady`.
- `sel` out 1: mux select; 1 = A, 0 = B.
- `gntA` out 1: A owns the port.
- `gntB` out 1: B owns the port.
- `memReq` out 1: access in progress toward memory.
- `doneA` out 1: one-cycle completion pulse for A.
- `doneB` out 1: one-cycle completion pulse for B.
- `err` out 1: one-cycle pulse coincident with done; the access timed out.
- `rdata` out 32: registered read data of the last successful access.
- `busy` out 1: state is not IDLE.

## Operation
- Sync reset effects:
  - state = IDLE; `lastA` = 0, so A wins the first tie.
  - `sel` = 1.
  - `gntA`, `gntB`, `memReq`, `doneA`, `doneB`, `err`, `busy` = 0; `rdata` = 0; counter = 0.
- There are four states; all outputs are registered and decoded from the state plus the owner flag.
- IDLE:
  - reqA&reqB: grant B if `lastA`=1, else grant A.
  - Single request: grant it.
  - None: stay in IDLE.
  - A grant moves the FSM to BUSY_A or BUSY_B and clears the counter.
  - `sel` holds its last value while idle.
- BUSY_A and BUSY_B:
  - Owner's `gnt` = 1, `memReq` = 1, `sel` = owner (A→1, B→0), stable for the whole state.
  - memReady=1: capture `memRdata` into `rdata`, go to DONE with err=0, update `lastA` to the owner.
  - memReady=0 with counter = TIMEOUT-1: go to DONE with err=1. `rdata` is unchanged and `lastA` is still updated.
  - Otherwise: counter += 1.
  - memReady and timeout on the same cycle: memReady wins.
- DONE:
  - Exactly one cycle: owner's `done` = 1, `err` as decided, `gnt`/`memReq` = 0, `busy` = 1.
  - All requests are ignored. Requesters must drop `req` by the end of this cycle unless they want another access.
  - Next state is always IDLE.
- Deassertion of `req` during BUSY is ignored; the access completes or times out.
- `memReady` outside BUSY is ignored.
- Rst mid-access: return to IDLE with reset values next cycle. No done pulse is generated and the access is abandoned.

## Timing
- Edge 0 samples a request in IDLE. Cycle 1: BUSY, `gnt`/`memReq`/`sel` valid.
- If `memReady` is sampled high at the end of BUSY cycle k, cycle k+1 is DONE: `done`=1 and `rdata` is valid, held until the next successful access.
- Minimum access is 3 cycles (IDLE→BUSY→DONE). Back-to-back accesses from the same requester start at most every 3 cycles.
- Maximum BUSY length is TIMEOUT cycles. The timeout DONE follows BUSY cycle TIMEOUT.
- `sel` changes only on the IDLE→BUSY edge, so the mux output is settled for the entire BUSY phase.

## Structure
- Shared package `mem_arb_pkg` holds:
  - State encoding localparams: IDLE=2'b00, BUSY_A=2'b01, BUSY_B=2'b10, DONE=2'b11.
  - `TIMEOUT`/`CNT_W` defaults.
  - The SEL_A=1 / SEL_B=0 constants shared with the 32-bit 2:1 mux instantiation.
- One sub-module, `timeout_counter`:
  - Ports: clear, enable, terminal-count flag.
  - Parameterised by `TIMEOUT` and `CNT_W`, synchronous clear on Rst.
- The FSM, round-robin pointer, and `rdata` register live in the top module.

## Test plan
- Reset then idle: hold Rst 2 cycles, no requests → all outputs 0, `sel`=1, `rdata`=0x00000000 for 10 cycles.
- Single A read: reqA=1, memReady high on the 3rd BUSY cycle with memRdata=0xDEADBEEF → gntA for 3 cycles, sel=1, then doneA pulse 1 cycle, `rdata`=0xDEADBEEF, err=0.
- Contention and fairness: reqA=reqB=1 held continuously, memReady=1 on the first BUSY cycle → grants alternate A,B,A,B after reset. `sel` reads 1,0,1,0 in BUSY. No requester is granted twice in a row.
- Timeout: TIMEOUT=4, reqB=1, memReady held 0 → exactly 4 BUSY cycles, then doneB=1 with err=1, `rdata` unchanged. The next tie goes to A.
- Ready/timeout collision: TIMEOUT=4, memReady=1 on BUSY cycle 4 with memRdata=0x12345678 → err=0, `rdata`=0x12345678.
- Reset mid-access: assert Rst on BUSY cycle 2 → next cycle IDLE, gnt/memReq=0, no done pulse. A later memReady is ignored.
